// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, one-cycle flush
// with PC redirect on exception/ERET, and a saturating stall-cycle counter.
//
//   state    | meaning
//   ST_RUN   | normal issue; stalls by highest requesting stage, accepts exc_valid
//   ST_DEFER | event accepted, waiting for MEM to finish before flushing
//   ST_FLUSH | one cycle: flush all stages and redirect PC to latched target
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_req_if,
   input  logic        stall_req_id,
   input  logic        stall_req_ex,
   input  logic        stall_req_mem,
   input  logic        exc_valid,
   input  logic [2:0]  exc_type,
   input  logic [31:0] cp0_epc,
   input  logic [31:0] exc_base,
   output logic [5:0]  stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DEFER = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [2:0]  EXC_ERET  = 3'd3;
   localparam logic [5:0]  STALL_ALL = 6'b111111;
   localparam logic [5:0]  STALL_MEM = 6'b011111;
   localparam logic [5:0]  STALL_EX  = 6'b001111;
   localparam logic [5:0]  STALL_ID  = 6'b000111;
   localparam logic [5:0]  STALL_IF  = 6'b000011;
   localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

   state_t      state_q, state_d;
   logic [31:0] target_q, target_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic        flush_q, flush_d;

   always_comb begin
      stall    = 6'b000000;
      state_d  = state_q;
      target_d = target_q;
      case (state_q)
         ST_RUN: begin
            if (exc_valid) begin
               target_d = (exc_type == EXC_ERET) ? cp0_epc : exc_base;
               // MEM must drain before the flush, so the event is deferred
               if (stall_req_mem) begin
                  stall   = STALL_MEM;
                  state_d = ST_DEFER;
               end else begin
                  stall   = STALL_ALL;
                  state_d = ST_FLUSH;
               end
            end else if (stall_req_mem) begin
               stall = STALL_MEM;
            end else if (stall_req_ex) begin
               stall = STALL_EX;
            end else if (stall_req_id) begin
               stall = STALL_ID;
            end else if (stall_req_if) begin
               stall = STALL_IF;
            end
         end
         ST_DEFER: begin
            if (stall_req_mem) begin
               stall = STALL_MEM;
            end else begin
               stall   = STALL_ALL;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      flush_d        = (state_d == ST_FLUSH);
      stall_cycles_d = ((stall != 6'b000000) && (stall_cycles_q != CNT_MAX)) ?
                       stall_cycles_q + 32'd1 : stall_cycles_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_RUN;
         target_q       <= 32'h0;
         stall_cycles_q <= 32'h0;
         flush_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         stall_cycles_q <= stall_cycles_d;
         flush_q        <= flush_d;
      end
   end

   assign flush          = flush_q;
   assign redirect_valid = flush_q;
   assign redirect_pc    = target_q;
   assign stall_cycles   = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: event-level reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_req_if = 1'b0, stall_req_id = 1'b0;
   logic        stall_req_ex = 1'b0, stall_req_mem = 1'b0;
   logic        exc_valid = 1'b0;
   logic [2:0]  exc_type = 3'd0;
   logic [31:0] cp0_epc = 32'h0, exc_base = 32'h0;
   logic [5:0]  stall;
   logic        flush, redirect_valid;
   logic [31:0] redirect_pc, stall_cycles;

   int n_total = 0;
   int n_pass  = 0;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
      .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
      .exc_valid(exc_valid), .exc_type(exc_type),
      .cp0_epc(cp0_epc), .exc_base(exc_base),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an accepted event is either waiting for MEM or is
   // being flushed this cycle; nothing else about the controller is tracked.
   bit          m_waiting;
   bit          m_flushing;
   logic [31:0] m_target;
   logic [31:0] m_cnt;

   function automatic logic [5:0] exp_stall();
      if (m_flushing) return 6'b000000;
      if (m_waiting || exc_valid) return stall_req_mem ? 6'b011111 : 6'b111111;
      if (stall_req_mem) return 6'b011111;
      if (stall_req_ex)  return 6'b001111;
      if (stall_req_id)  return 6'b000111;
      if (stall_req_if)  return 6'b000011;
      return 6'b000000;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_waiting = 0; m_flushing = 0; m_target = 32'h0; m_cnt = 32'h0;
      end else begin
         if (exp_stall() != 6'b000000 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (m_flushing) m_flushing = 0;
         else if (m_waiting) begin
            if (!stall_req_mem) begin m_waiting = 0; m_flushing = 1; end
         end else if (exc_valid) begin
            m_target = (exc_type == 3'd3) ? cp0_epc : exc_base;
            if (stall_req_mem) m_waiting = 1; else m_flushing = 1;
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_stall", {26'h0, stall}, {26'h0, exp_stall()});
      check("cmp_flush", {31'h0, flush}, {31'h0, m_flushing});
      check("cmp_redirect_valid", {31'h0, redirect_valid}, {31'h0, m_flushing});
      check("cmp_redirect_pc", redirect_pc, m_target);
      check("cmp_stall_cycles", stall_cycles, m_cnt);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
      stall_req_if = i_if; stall_req_id = i_id; stall_req_ex = i_ex; stall_req_mem = i_mem;
   endtask

   typedef struct { logic [3:0] req; logic [5:0] exp; } vec_t;
   vec_t vecs[6];

   initial begin
      vecs[0] = '{4'b0001, 6'b000011};
      vecs[1] = '{4'b0010, 6'b000111};
      vecs[2] = '{4'b0110, 6'b001111};
      vecs[3] = '{4'b1001, 6'b011111};
      vecs[4] = '{4'b0100, 6'b001111};
      vecs[5] = '{4'b1111, 6'b011111};

      #2;
      check("reset_stall", {26'h0, stall}, 32'h0);
      check("reset_flush", {31'h0, flush}, 32'h0);
      check("reset_redirect_pc", redirect_pc, 32'h0);
      check("reset_stall_cycles", stall_cycles, 32'h0);
      @(negedge clk); #1 rst = 1'b1;
      tick(); tick();

      // stall priority in RUN
      foreach (vecs[k]) begin
         set_req(vecs[k].req[0], vecs[k].req[1], vecs[k].req[2], vecs[k].req[3]);
         #1 check("prio_stall", {26'h0, stall}, {26'h0, vecs[k].exp});
         tick();
      end
      set_req(0, 0, 0, 0);
      tick();
      check("count_after_prio", stall_cycles, 32'd6);

      // exception, no MEM wait
      exc_valid = 1; exc_type = 3'd1; exc_base = 32'hBFC0_0380; cp0_epc = 32'h1111_2222;
      #1 check("exc_accept_stall", {26'h0, stall}, 32'h3F);
      tick();
      exc_valid = 0; exc_base = 32'h0;
      #1 check("exc_flush", {31'h0, flush}, 32'h1);
      check("exc_redirect_valid", {31'h0, redirect_valid}, 32'h1);
      check("exc_redirect_pc", redirect_pc, 32'hBFC0_0380);
      check("exc_flush_stall", {26'h0, stall}, 32'h0);
      tick();
      check("exc_flush_done", {31'h0, flush}, 32'h0);
      check("exc_pc_held", redirect_pc, 32'hBFC0_0380);

      // ERET with MEM wait; second event during DEFER/FLUSH ignored
      exc_valid = 1; exc_type = 3'd3; cp0_epc = 32'h8000_1000; exc_base = 32'hBFC0_0380;
      set_req(0, 0, 0, 1);
      #1 check("eret_accept_stall", {26'h0, stall}, 32'h1F);
      for (int c = 0; c < 2; c++) begin
         tick();
         exc_type = 3'd1; exc_base = 32'h0; set_req(1, 1, 1, 1);
         #1 check("defer_stall", {26'h0, stall}, 32'h1F);
         check("defer_no_flush", {31'h0, flush}, 32'h0);
      end
      tick();
      set_req(1, 0, 1, 0);
      #1 check("defer_release_stall", {26'h0, stall}, 32'h3F);
      tick();
      #1 check("eret_flush", {31'h0, flush}, 32'h1);
      check("eret_redirect_pc", redirect_pc, 32'h8000_1000);
      check("eret_flush_stall", {26'h0, stall}, 32'h0);
      tick();
      exc_valid = 0; set_req(0, 0, 0, 0);
      #1 check("eret_flush_done", {31'h0, flush}, 32'h0);
      check("eret_pc_held", redirect_pc, 32'h8000_1000);
      tick();

      // reset pulse during DEFER aborts the pending redirect
      exc_valid = 1; exc_type = 3'd1; exc_base = 32'h1234_5678; set_req(0, 0, 0, 1);
      tick();
      exc_valid = 0;
      tick();
      #1 rst = 1'b0; set_req(0, 0, 0, 0);
      #1 check("rst_stall", {26'h0, stall}, 32'h0);
      check("rst_flush", {31'h0, flush}, 32'h0);
      check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      check("rst_stall_cycles", stall_cycles, 32'h0);
      @(negedge clk); #1 rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("post_rst_no_flush", {31'h0, flush}, 32'h0);
      end

      // saturation of the stall counter
      force dut.stall_cycles_q = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      tick();
      release dut.stall_cycles_q;
      set_req(1, 0, 0, 0);
      tick();
      check("sat_step1", stall_cycles, 32'hFFFF_FFFF);
      tick(); tick(); tick();
      check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
      set_req(0, 0, 0, 0);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
